pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard controller for the 5-stage core. Each cycle it generates the 2-bit data_ctrl command (NORMAL/FLUSH/STOP) for the PC register and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It covers:
- post-reset pipeline flush
- DRAM wait-state stalls, with a timeout
- taken-branch flushes
- load-use bubbles

Parameters:
INIT_CYCLES, 4, cycles of forced flush after reset release (>=1)
MEM_TIMEOUT, 16, max cycles in memory wait before forced release (>=2)
CNT_W, 32, width of performance counters

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
id_rs1_i  in  5  rs1 index of instruction in ID
id_rs2_i  in  5  rs2 index of instruction in ID
id_rs1_use_i  in  1  ID instruction reads rs1
id_rs2_use_i  in  1  ID instruction reads rs2
ex_is_load_i  in  1  instruction in EX is a load
ex_wR_i  in  5  destination register of EX instruction
ex_br_taken_i  in  1  EX resolved a taken branch/jump
mem_req_i  in  1  MEM stage has an active DRAM access
mem_ack_i  in  1  DRAM completes access this cycle
pc_ctrl_o  out  2  PC register command
ifid_ctrl_o  out  2  IF/ID command
idex_ctrl_o  out  2  ID/EX command
exmem_ctrl_o  out  2  EX/MEM command
memwb_ctrl_o  out  2  MEM/WB command
mem_err_o  out  1  sticky memory-timeout flag
stall_cnt_o  out  CNT_W  stall cycles (optional feature)
flush_cnt_o  out  CNT_W  branch-flush events (optional feature)

Behaviour:
- Encoding: NORMAL=2'b00, FLUSH=2'b01, STOP=2'b10. This block never drives 2'b11.
- All ctrl outputs are combinational from the registered state and the current inputs. The pipeline registers consume them at the same posedge.
- FSM states:
  - S_INIT: on reset. init_cnt counts 0..INIT_CYCLES-1, then the FSM goes to S_RUN.
  - S_RUN: normal operation.
  - S_MEM_WAIT: waiting on DRAM. Holds a wait counter.
- Reset (async) state:
  - state=S_INIT, init_cnt=0, wait_cnt=0, mem_err_o=0, counters=0.
  - Outputs: pc_ctrl_o=STOP, all four pipeline ctrls=FLUSH.
- S_INIT: outputs as at reset. Memory, branch and load-use inputs are ignored.
- S_RUN priority, highest first:
  1. mem stall (mem_req_i & !mem_ack_i):
     - pc, IF/ID, ID/EX, EX/MEM = STOP; MEM/WB = FLUSH.
     - Next state S_MEM_WAIT, wait_cnt=1.
  2. branch (ex_br_taken_i):
     - IF/ID = FLUSH, ID/EX = FLUSH; pc, EX/MEM, MEM/WB = NORMAL.
  3. load-use (ex_is_load_i & ex_wR_i!=0 & ((id_rs1_use_i & id_rs1_i==ex_wR_i) | (id_rs2_use_i & id_rs2_i==ex_wR_i))):
     - pc = STOP, IF/ID = STOP, ID/EX = FLUSH; EX/MEM, MEM/WB = NORMAL.
  4. Otherwise all NORMAL.
- Zero-wait access (mem_req_i & mem_ack_i in the same cycle) causes no stall.
- S_MEM_WAIT:
  - Outputs as the mem-stall case.
  - When mem_ack_i=1, that cycle outputs all NORMAL and the FSM goes to S_RUN.
  - Branch and load-use are not evaluated here. Held stages re-present them after release.
  - Timeout: if wait_cnt==MEM_TIMEOUT-1 and !mem_ack_i:
    - Set mem_err_o=1; it stays set until reset.
    - That cycle is treated as an ack (all NORMAL), and the FSM goes to S_RUN.
  - Otherwise wait_cnt increments.
- Branch and load-use in the same cycle: branch wins.
- A branch coincident with a mem stall is deferred. EX/MEM is held, so the branch re-evaluates after release.
- Reset asserted mid-wait or mid-init aborts immediately to reset values.

Optional Feature:
Macro PIPE_HAZARD_PERF_EN.
- Defined:
  - stall_cnt_o increments every cycle pc_ctrl_o==STOP in S_RUN/S_MEM_WAIT.
  - flush_cnt_o increments on each branch flush.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports are tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset, release with INIT_CYCLES=4 -> 4 cycles of pc=STOP/all FLUSH, then all NORMAL on cycle 5.
- ex_is_load_i=1, ex_wR_i=5, id_rs1_i=5, id_rs1_use_i=1 -> pc=STOP, ifid=STOP, idex=FLUSH, exmem=memwb=NORMAL for 1 cycle. Same stimulus with ex_wR_i=0 -> all NORMAL.
- mem_req_i=1, mem_ack_i low 3 cycles then high -> 3 stall cycles (memwb=FLUSH, others STOP), all NORMAL on ack cycle, mem_err_o=0.
- mem_req_i=1, ack never, MEM_TIMEOUT=16 -> 15 stall cycles, then release with mem_err_o=1 held until reset.
- ex_br_taken_i=1 with load-use hazard present -> ifid=idex=FLUSH, pc=NORMAL. With PIPE_HAZARD_PERF_EN, flush_cnt_o goes 0->1.
- ex_br_taken_i=1 coincident with mem_req_i & !mem_ack_i -> stall outputs, no flush until ack; flush occurs on the first S_RUN cycle after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central hazard controller for the 5-stage core.
// Each cycle it issues a NORMAL/FLUSH/STOP command to the PC register and to
// the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It covers the
// post-reset flush, DRAM wait-state stalls with a timeout, taken-branch
// flushes and load-use bubbles.
//
// Optional feature macro: PIPE_HAZARD_PERF_EN (saturating stall/flush counters).
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   id_rs1_i/id_rs2_i       source register indices of the ID instruction
//   id_rs1_use_i/_rs2_use_i ID instruction actually reads rs1/rs2
//   ex_is_load_i, ex_wR_i   EX instruction is a load / its destination
//   ex_br_taken_i           EX resolved a taken branch or jump
//   mem_req_i, mem_ack_i    MEM-stage DRAM request / completion
//   *_ctrl_o                per-register commands (combinational)
//   mem_err_o               sticky memory-timeout flag
//   stall_cnt_o/flush_cnt_o performance counters (zero without the macro)
module pipe_hazard_ctrl #(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_use_i,
  input  logic             id_rs2_use_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_wR_i,
  input  logic             ex_br_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic [1:0]       pc_ctrl_o,
  output logic [1:0]       ifid_ctrl_o,
  output logic [1:0]       idex_ctrl_o,
  output logic [1:0]       exmem_ctrl_o,
  output logic [1:0]       memwb_ctrl_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [1:0] CTRL_NORMAL = 2'b00;
  localparam logic [1:0] CTRL_FLUSH  = 2'b01;
  localparam logic [1:0] CTRL_STOP   = 2'b10;

  localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_INIT     = 2'b00,
    S_RUN      = 2'b01,
    S_MEM_WAIT = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;

  logic mem_stall_c;
  logic load_use_c;
  logic init_last_c;
  logic timeout_c;

  assign mem_stall_c = mem_req_i & ~mem_ack_i;
  assign load_use_c  = ex_is_load_i & (ex_wR_i != 5'd0) &
                       ((id_rs1_use_i & (id_rs1_i == ex_wR_i)) |
                        (id_rs2_use_i & (id_rs2_i == ex_wR_i)));
  assign init_last_c = (init_cnt_q == INIT_W'(INIT_CYCLES - 1));
  // Last permitted wait cycle without an ack: release anyway and flag it.
  assign timeout_c   = ~mem_ack_i & (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      S_INIT: begin
        if (init_last_c) begin
          state_d    = S_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      S_RUN: begin
        if (mem_stall_c) begin
          state_d    = S_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      S_MEM_WAIT: begin
        if (mem_ack_i || timeout_c) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
          if (timeout_c) mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Output logic: stall beats branch beats load-use
  always_comb begin
    pc_ctrl_o    = CTRL_NORMAL;
    ifid_ctrl_o  = CTRL_NORMAL;
    idex_ctrl_o  = CTRL_NORMAL;
    exmem_ctrl_o = CTRL_NORMAL;
    memwb_ctrl_o = CTRL_NORMAL;
    unique case (state_q)
      S_RUN: begin
        if (mem_stall_c) begin
          pc_ctrl_o    = CTRL_STOP;
          ifid_ctrl_o  = CTRL_STOP;
          idex_ctrl_o  = CTRL_STOP;
          exmem_ctrl_o = CTRL_STOP;
          memwb_ctrl_o = CTRL_FLUSH;
        end else if (ex_br_taken_i) begin
          ifid_ctrl_o  = CTRL_FLUSH;
          idex_ctrl_o  = CTRL_FLUSH;
        end else if (load_use_c) begin
          pc_ctrl_o    = CTRL_STOP;
          ifid_ctrl_o  = CTRL_STOP;
          idex_ctrl_o  = CTRL_FLUSH;
        end
      end
      S_MEM_WAIT: begin
        if (!(mem_ack_i || timeout_c)) begin
          pc_ctrl_o    = CTRL_STOP;
          ifid_ctrl_o  = CTRL_STOP;
          idex_ctrl_o  = CTRL_STOP;
          exmem_ctrl_o = CTRL_STOP;
          memwb_ctrl_o = CTRL_FLUSH;
        end
      end
      default: begin
        pc_ctrl_o    = CTRL_STOP;
        ifid_ctrl_o  = CTRL_FLUSH;
        idex_ctrl_o  = CTRL_FLUSH;
        exmem_ctrl_o = CTRL_FLUSH;
        memwb_ctrl_o = CTRL_FLUSH;
      end
    endcase
  end

  assign mem_err_o = mem_err_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic             stall_evt_c;
  logic             flush_evt_c;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  assign stall_evt_c = (state_q != S_INIT) & (pc_ctrl_o == CTRL_STOP);
  assign flush_evt_c = (state_q == S_RUN) & ~mem_stall_c & ex_br_taken_i;

  // Saturating performance counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt_c && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned INIT_CYCLES = 4;
  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 32;

  localparam logic [1:0] NRM = 2'b00;
  localparam logic [1:0] FL  = 2'b01;
  localparam logic [1:0] ST  = 2'b10;

  // Command vectors ordered {pc, ifid, idex, exmem, memwb}
  localparam logic [9:0] V_INIT  = {ST, FL, FL, FL, FL};
  localparam logic [9:0] V_STALL = {ST, ST, ST, ST, FL};
  localparam logic [9:0] V_BR    = {NRM, FL, FL, NRM, NRM};
  localparam logic [9:0] V_LU    = {ST, ST, FL, NRM, NRM};
  localparam logic [9:0] V_NRM   = 10'd0;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [4:0]       id_rs1_i, id_rs2_i, ex_wR_i;
  logic             id_rs1_use_i, id_rs2_use_i, ex_is_load_i, ex_br_taken_i;
  logic             mem_req_i, mem_ack_i;
  logic [1:0]       pc_ctrl_o, ifid_ctrl_o, idex_ctrl_o, exmem_ctrl_o, memwb_ctrl_o;
  logic             mem_err_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic [9:0]       ctrl_w;

  pipe_hazard_ctrl #(
    .INIT_CYCLES(INIT_CYCLES),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_rs1_use_i (id_rs1_use_i),
    .id_rs2_use_i (id_rs2_use_i),
    .ex_is_load_i (ex_is_load_i),
    .ex_wR_i      (ex_wR_i),
    .ex_br_taken_i(ex_br_taken_i),
    .mem_req_i    (mem_req_i),
    .mem_ack_i    (mem_ack_i),
    .pc_ctrl_o    (pc_ctrl_o),
    .ifid_ctrl_o  (ifid_ctrl_o),
    .idex_ctrl_o  (idex_ctrl_o),
    .exmem_ctrl_o (exmem_ctrl_o),
    .memwb_ctrl_o (memwb_ctrl_o),
    .mem_err_o    (mem_err_o),
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o)
  );

  assign ctrl_w = {pc_ctrl_o, ifid_ctrl_o, idex_ctrl_o, exmem_ctrl_o, memwb_ctrl_o};

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Model state: flush cycles still owed after reset, stall cycles already
  // served for the current DRAM access (0 = not waiting), sticky error, counters.
  int          init_left;
  int          served;
  bit          m_err;
  longint      m_stall;
  longint      m_flush;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic ld, input logic [4:0] wr,
                        input logic br, input logic req, input logic ack);
    id_rs1_i = rs1; id_rs2_i = rs2; id_rs1_use_i = u1; id_rs2_use_i = u2;
    ex_is_load_i = ld; ex_wR_i = wr; ex_br_taken_i = br;
    mem_req_i = req; mem_ack_i = ack;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_regs();
    check_val("mem_err", 64'(mem_err_o), 64'(m_err));
`ifdef PIPE_HAZARD_PERF_EN
    check_val("stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
    check_val("flush_cnt", 64'(flush_cnt_o), 64'(m_flush));
`else
    check_val("stall_cnt", 64'(stall_cnt_o), 64'd0);
    check_val("flush_cnt", 64'(flush_cnt_o), 64'd0);
`endif
  endtask

  // Called at a negedge with inputs set; checks this cycle, steps one clock.
  task automatic cycle();
    logic [9:0] exp;
    bit lu;
    bit running;
    #1;
    running = (init_left == 0);
    lu = ex_is_load_i && (ex_wR_i != 5'd0) &&
         ((id_rs1_use_i && id_rs1_i == ex_wR_i) || (id_rs2_use_i && id_rs2_i == ex_wR_i));
    if (!running) begin
      exp = V_INIT;
      init_left--;
    end else if (served > 0) begin
      if (mem_ack_i) begin
        exp = V_NRM; served = 0;
      end else if (served == MEM_TIMEOUT - 1) begin
        exp = V_NRM; served = 0; m_err = 1'b1;
      end else begin
        exp = V_STALL; served++;
      end
    end else if (mem_req_i && !mem_ack_i) begin
      exp = V_STALL; served = 1;
    end else if (ex_br_taken_i) begin
      exp = V_BR;
      if (m_flush < CNT_MAX) m_flush++;
    end else if (lu) begin
      exp = V_LU;
    end else begin
      exp = V_NRM;
    end
    if (running && exp[9:8] == ST && m_stall < CNT_MAX) m_stall++;
    check_val("ctrl", 64'(ctrl_w), 64'(exp));
    @(posedge clk_i);
    #1;
    check_regs();
    @(negedge clk_i);
  endtask

  // Called at a negedge: asynchronous assert, check, hold one edge, release.
  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    check_val("rst_ctrl", 64'(ctrl_w), 64'(V_INIT));
    init_left = INIT_CYCLES; served = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    check_regs();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    idle();
    @(negedge clk_i);
    do_reset();
    repeat (INIT_CYCLES + 2) cycle();

    // Load-use bubble, then the same with x0 as destination
    set_in(5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); cycle();
    set_in(5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); cycle();
    set_in(5'd3, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); cycle();
    idle(); cycle();

    // Three wait states then ack; zero-wait access
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); repeat (3) cycle();
    mem_ack_i = 1'b1; cycle();
    cycle();
    idle(); cycle();

    // Timeout: no ack ever
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); repeat (MEM_TIMEOUT) cycle();
    idle(); repeat (3) cycle();

    // Branch beats load-use
    set_in(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0); cycle();
    idle(); cycle();

    // Branch deferred by a memory stall, flushes after release
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); repeat (2) cycle();
    mem_ack_i = 1'b1; cycle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); cycle();
    idle(); cycle();

    // Reset in the middle of a wait clears everything including the error
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); repeat (3) cycle();
    do_reset();
    idle(); repeat (INIT_CYCLES + 1) cycle();

    // Randomized traffic with a small register space to provoke hazards
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        do_reset();
      end
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 3) == 0));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
